// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order issue queue for load/store micro-ops feeding the AGU.
// Entries are held in program order in a circular buffer. Each entry captures
// its source operand values from the writeback buses. The oldest entry is
// offered to the AGU once both of its sources hold values.
//
// Ports:
//   clk, reset, flush           clock, sync active-high reset, flush (same as reset)
//   dispatch_valid/ready        enqueue handshake; ready = !full
//   dispatch_inst               payload (operation, imm, phy_dest, rob, src values)
//   dispatch_srcN_tag/ready     physical source tags / value-already-valid flags
//   wb_valid/phy_dest/result    writeback wakeup buses (WB_PORTS of them)
//   issue_to_agu_valid          head entry is issuable
//   agu_allowin                 AGU accepts this cycle
//   issue_inst                  head entry payload with captured source values
//   mq_count                    number of occupied entries

package mem_issue_queue_pkg;
  typedef struct packed {
    logic [5:0]  operation;
    logic [31:0] imm;
  } inst_t;

  typedef struct packed {
    inst_t       inst;
    logic [5:0]  phy_dest;
    logic [5:0]  rob_entry_num;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
  } issue_to_execute_bus_t;
endpackage

module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  issue_to_execute_bus_t         dispatch_inst,
  input  logic [5:0]                    dispatch_src1_tag,
  input  logic [5:0]                    dispatch_src2_tag,
  input  logic                          dispatch_src1_ready,
  input  logic                          dispatch_src2_ready,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS-1:0][5:0]      wb_phy_dest,
  input  logic [WB_PORTS-1:0][31:0]     wb_result,
  output logic                          issue_to_agu_valid,
  input  logic                          agu_allowin,
  output issue_to_execute_bus_t         issue_inst,
  output logic [$clog2(DEPTH):0]        mq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  issue_to_execute_bus_t ent_q  [DEPTH];
  issue_to_execute_bus_t ent_d  [DEPTH];
  logic [5:0]            tag1_q [DEPTH];
  logic [5:0]            tag1_d [DEPTH];
  logic [5:0]            tag2_q [DEPTH];
  logic [5:0]            tag2_d [DEPTH];
  logic [DEPTH-1:0]      rdy1_q, rdy1_d;
  logic [DEPTH-1:0]      rdy2_q, rdy2_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic full, empty, enq, deq;
  logic [32:0] lk;

  // Returns {hit, value}; the loop runs high-to-low so the lowest bus wins.
  function automatic logic [32:0] wb_lookup(
    input logic [5:0]                tag,
    input logic [WB_PORTS-1:0]       v,
    input logic [WB_PORTS-1:0][5:0]  t,
    input logic [WB_PORTS-1:0][31:0] r
  );
    logic [32:0] res;
    res = '0;
    for (int unsigned k = WB_PORTS; k > 0; k--) begin
      if (v[k-1] && (t[k-1] == tag)) res = {1'b1, r[k-1]};
    end
    return res;
  endfunction

  assign full               = (cnt_q == CW'(DEPTH));
  assign empty              = (cnt_q == '0);
  assign dispatch_ready     = !full;
  assign issue_to_agu_valid = !empty && rdy1_q[head_q] && rdy2_q[head_q];
  assign issue_inst         = ent_q[head_q];
  assign mq_count           = cnt_q;
  assign enq                = dispatch_valid && !full;
  assign deq                = issue_to_agu_valid && agu_allowin;

  always_comb begin
    ent_d  = ent_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    lk     = '0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !rdy1_q[i]) begin
        lk = wb_lookup(tag1_q[i], wb_valid, wb_phy_dest, wb_result);
        if (lk[32]) begin
          rdy1_d[i]           = 1'b1;
          ent_d[i].src1_value = lk[31:0];
        end
      end
      if (vld_q[i] && !rdy2_q[i]) begin
        lk = wb_lookup(tag2_q[i], wb_valid, wb_phy_dest, wb_result);
        if (lk[32]) begin
          rdy2_d[i]           = 1'b1;
          ent_d[i].src2_value = lk[31:0];
        end
      end
    end

    if (deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end

    // Enqueue never aliases the dequeued slot: tail == head only when empty
    // (no dequeue) or full (no enqueue).
    if (enq) begin
      ent_d[tail_q]  = dispatch_inst;
      tag1_d[tail_q] = dispatch_src1_tag;
      tag2_d[tail_q] = dispatch_src2_tag;
      vld_d[tail_q]  = 1'b1;
      if (dispatch_src1_ready || (dispatch_src1_tag == '0)) begin
        rdy1_d[tail_q] = 1'b1;
      end else begin
        lk = wb_lookup(dispatch_src1_tag, wb_valid, wb_phy_dest, wb_result);
        rdy1_d[tail_q] = lk[32];
        if (lk[32]) ent_d[tail_q].src1_value = lk[31:0];
      end
      if (dispatch_src2_ready || (dispatch_src2_tag == '0)) begin
        rdy2_d[tail_q] = 1'b1;
      end else begin
        lk = wb_lookup(dispatch_src2_tag, wb_valid, wb_phy_dest, wb_result);
        rdy2_d[tail_q] = lk[32];
        if (lk[32]) ent_d[tail_q].src2_value = lk[31:0];
      end
      tail_d = tail_q + 1'b1;
    end

    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]  <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
      end
      rdy1_q <= '0;
      rdy2_q <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned WB_PORTS = 2;
  localparam logic [5:0] OP_LW = 6'd1;
  localparam logic [5:0] OP_SW = 6'd2;

  logic                      clk = 1'b0;
  logic                      reset, flush;
  logic                      dispatch_valid, dispatch_ready;
  issue_to_execute_bus_t     dispatch_inst, issue_inst;
  logic [5:0]                dispatch_src1_tag, dispatch_src2_tag;
  logic                      dispatch_src1_ready, dispatch_src2_ready;
  logic [WB_PORTS-1:0]       wb_valid;
  logic [WB_PORTS-1:0][5:0]  wb_phy_dest;
  logic [WB_PORTS-1:0][31:0] wb_result;
  logic                      issue_to_agu_valid, agu_allowin;
  logic [$clog2(DEPTH):0]    mq_count;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int pushes = 0;
  issue_to_execute_bus_t sb[$];

  mem_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_inst(dispatch_inst),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src2_ready(dispatch_src2_ready),
    .wb_valid(wb_valid), .wb_phy_dest(wb_phy_dest), .wb_result(wb_result),
    .issue_to_agu_valid(issue_to_agu_valid), .agu_allowin(agu_allowin),
    .issue_inst(issue_inst), .mq_count(mq_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic issue_to_execute_bus_t mk(input logic [5:0] op, input logic [31:0] imm,
      input logic [5:0] pd, input logic [5:0] rob, input logic [31:0] s1, input logic [31:0] s2);
    issue_to_execute_bus_t b;
    b.inst.operation = op;
    b.inst.imm       = imm;
    b.phy_dest       = pd;
    b.rob_entry_num  = rob;
    b.src1_value     = s1;
    b.src2_value     = s2;
    return b;
  endfunction

  // Monitor: every accepted issue is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && issue_to_agu_valid && agu_allowin) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_issue: got unexpected issue %0h expected none", issue_inst);
      end else begin
        issue_to_execute_bus_t e;
        e = sb.pop_front();
        if (issue_inst !== e) begin
          errors++;
          $display("FAIL sb_issue: got %0h expected %0h", issue_inst, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    dispatch_valid      = 1'b0;
    dispatch_inst       = '0;
    dispatch_src1_tag   = '0;
    dispatch_src2_tag   = '0;
    dispatch_src1_ready = 1'b0;
    dispatch_src2_ready = 1'b0;
    wb_valid            = '0;
    wb_phy_dest         = '0;
    wb_result           = '0;
  endtask

  task automatic drv(input issue_to_execute_bus_t b, input logic [5:0] t1, input logic r1,
      input logic [5:0] t2, input logic r2);
    dispatch_valid      = 1'b1;
    dispatch_inst       = b;
    dispatch_src1_tag   = t1;
    dispatch_src1_ready = r1;
    dispatch_src2_tag   = t2;
    dispatch_src2_ready = r2;
  endtask

  task automatic set_wb(input int unsigned k, input logic [5:0] tag, input logic [31:0] val);
    wb_valid[k]    = 1'b1;
    wb_phy_dest[k] = tag;
    wb_result[k]   = val;
  endtask

  initial begin
    issue_to_execute_bus_t bp_exp;
    bit done;
    idle();
    reset = 1'b1;
    flush = 1'b0;
    agu_allowin = 1'b0;
    tick();
    tick();
    at_neg();
    chk("rst_ready", 128'(dispatch_ready), 128'(1));
    chk("rst_valid", 128'(issue_to_agu_valid), 128'(0));
    chk("rst_count", 128'(mq_count), 128'(0));
    chk("rst_inst", 128'(issue_inst), 128'(0));
    reset = 1'b0;

    // Single op: LW, src1 ready 0x1000, imm 4, rob 3.
    tick();
    agu_allowin = 1'b1;
    drv(mk(OP_LW, 32'h4, 6'd9, 6'd3, 32'h1000, 32'h0), 6'd7, 1'b1, 6'd0, 1'b1);
    sb.push_back(mk(OP_LW, 32'h4, 6'd9, 6'd3, 32'h1000, 32'h0)); pushes++;
    at_neg();
    chk("single_no_bypass", 128'(issue_to_agu_valid), 128'(0));
    tick();
    idle();
    at_neg();
    chk("single_valid", 128'(issue_to_agu_valid), 128'(1));
    chk("single_count1", 128'(mq_count), 128'(1));
    tick();
    at_neg();
    chk("single_count0", 128'(mq_count), 128'(0));

    // Wakeup: SW, src2 tag 12 pending, woken two cycles later on bus 1.
    tick();
    drv(mk(OP_SW, 32'h8, 6'd0, 6'd4, 32'h2000, 32'h1111), 6'd3, 1'b1, 6'd12, 1'b0);
    sb.push_back(mk(OP_SW, 32'h8, 6'd0, 6'd4, 32'h2000, 32'hDEADBEEF)); pushes++;
    tick();
    idle();
    at_neg();
    chk("wake_wait1", 128'(issue_to_agu_valid), 128'(0));
    tick();
    set_wb(1, 6'd12, 32'hDEADBEEF);
    at_neg();
    chk("wake_wbcycle", 128'(issue_to_agu_valid), 128'(0));
    tick();
    idle();
    at_neg();
    chk("wake_valid", 128'(issue_to_agu_valid), 128'(1));
    tick();

    // Same-cycle capture on bus 0; src2 tag 0 counts as ready without the flag.
    drv(mk(OP_LW, 32'h10, 6'd11, 6'd5, 32'h0, 32'h77), 6'd5, 1'b0, 6'd0, 1'b0);
    set_wb(0, 6'd5, 32'h55);
    sb.push_back(mk(OP_LW, 32'h10, 6'd11, 6'd5, 32'h55, 32'h77)); pushes++;
    tick();
    idle();
    at_neg();
    chk("same_cycle_valid", 128'(issue_to_agu_valid), 128'(1));
    tick();

    // In-order and full: head pending on tag 20, seven ready ops behind it;
    // the head pointer starts at 3 so the buffer wraps.
    for (int i = 0; i < 8; i++) begin
      if (i == 0)
        drv(mk(OP_LW, 32'(i), 6'd30, 6'(10 + i), 32'h0, 32'h0), 6'd20, 1'b0, 6'd0, 1'b1);
      else
        drv(mk(OP_SW, 32'(i), 6'd0, 6'(10 + i), 32'(100 + i), 32'(200 + i)), 6'd21, 1'b1, 6'd22, 1'b1);
      if (i == 0) sb.push_back(mk(OP_LW, 32'(i), 6'd30, 6'(10 + i), 32'hABCD, 32'h0));
      else        sb.push_back(mk(OP_SW, 32'(i), 6'd0, 6'(10 + i), 32'(100 + i), 32'(200 + i)));
      pushes++;
      tick();
    end
    // Attempt a ninth dispatch while full; it must be refused.
    drv(mk(OP_SW, 32'hF, 6'd0, 6'd40, 32'h1, 32'h2), 6'd21, 1'b1, 6'd22, 1'b1);
    at_neg();
    chk("full_ready", 128'(dispatch_ready), 128'(0));
    chk("full_count", 128'(mq_count), 128'(8));
    chk("full_no_issue", 128'(issue_to_agu_valid), 128'(0));
    tick();
    idle();
    at_neg();
    chk("full_refused", 128'(mq_count), 128'(8));
    tick();
    set_wb(0, 6'd20, 32'hABCD);
    tick();
    idle();
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      at_neg();
      if (mq_count == 0) done = 1'b1;
      else tick();
    end
    chk("drain_done", 128'(done), 128'(1));
    chk("drain_count", 128'(mq_count), 128'(0));
    tick();

    // Backpressure: head valid for three cycles with agu_allowin low.
    agu_allowin = 1'b0;
    bp_exp = mk(OP_LW, 32'h20, 6'd12, 6'd21, 32'h3000, 32'h4000);
    drv(bp_exp, 6'd1, 1'b1, 6'd2, 1'b1);
    sb.push_back(bp_exp); pushes++;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("bp_valid", 128'(issue_to_agu_valid), 128'(1));
      chk("bp_stable", 128'(issue_inst), 128'(bp_exp));
      tick();
    end
    agu_allowin = 1'b1;
    tick();
    at_neg();
    chk("bp_dequeued", 128'(mq_count), 128'(0));
    chk("bp_once", 128'(pops), 128'(pushes));
    tick();

    // Flush with five entries while an enqueue and a wakeup are active.
    agu_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(mk(OP_SW, 32'(i), 6'd0, 6'(50 + i), 32'h0, 32'h0), 6'd33, 1'b0, 6'd0, 1'b1);
      tick();
    end
    at_neg();
    chk("pre_flush_count", 128'(mq_count), 128'(5));
    drv(mk(OP_LW, 32'h0, 6'd1, 6'd60, 32'h9, 32'h9), 6'd1, 1'b1, 6'd2, 1'b1);
    set_wb(0, 6'd33, 32'h3333);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    at_neg();
    chk("flush_count", 128'(mq_count), 128'(0));
    chk("flush_valid", 128'(issue_to_agu_valid), 128'(0));
    chk("flush_ready", 128'(dispatch_ready), 128'(1));
    agu_allowin = 1'b1;
    tick();
    tick();
    at_neg();
    chk("post_flush_count", 128'(mq_count), 128'(0));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("sb_pops", 128'(pops), 128'(pushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
